// File: rtl/ls_pkg.sv
// Shared types and constants for the SPU local-store port arbiter.
package ls_pkg;

  // Requester identity carried with each granted access.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DMA,
    SRC_LS,
    SRC_IF
  } ls_src_t;

  localparam int unsigned LS_BYTES = 32768;
  localparam int unsigned QW_BYTES = 16;
  localparam int unsigned QW_IDX_W = 11;

endpackage

// File: rtl/ls_rd_tag_pipe.sv
// Read-tag shift pipeline: carries {valid, source} alongside the array read latency so
// that each returning quadword is steered to the requester that issued it.
module ls_rd_tag_pipe
  import ls_pkg::*;
#(
  parameter int unsigned DEPTH = 3  // must be >= 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  ls_src_t in_src,
  output logic    pre_valid,  // stage aligned with valid mem_rdata
  output logic    dma_rvalid,
  output logic    ls_rvalid,
  output logic    if_rvalid
);

  logic [DEPTH-1:0] vld;
  ls_src_t          src [DEPTH];

  // Shift tags one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) src[i] <= SRC_NONE;
    end else begin
      vld    <= {vld[DEPTH-2:0], in_valid};
      src[0] <= in_src;
      for (int i = 1; i < DEPTH; i++) src[i] <= src[i-1];
    end
  end

  assign pre_valid  = vld[DEPTH-2];
  assign dma_rvalid = vld[DEPTH-1] && (src[DEPTH-1] == SRC_DMA);
  assign ls_rvalid  = vld[DEPTH-1] && (src[DEPTH-1] == SRC_LS);
  assign if_rvalid  = vld[DEPTH-1] && (src[DEPTH-1] == SRC_IF);

endmodule

// File: rtl/ls_port_arbiter.sv
// Local-store port arbiter: DMA > LS > IF fixed priority with an instruction-fetch
// starvation override, one registered quadword command per cycle, and read-return steering.
module ls_port_arbiter
  import ls_pkg::*;
#(
  parameter int unsigned AW         = 15,
  parameter int unsigned DW         = 128,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dma_req,
  input  logic          ls_req,
  input  logic          if_req,
  input  logic          dma_we,
  input  logic          ls_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [AW-1:0] ls_addr,
  input  logic [AW-1:0] if_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [DW-1:0] ls_wdata,
  output logic          dma_gnt,
  output logic          ls_gnt,
  output logic          if_gnt,
  output logic          dma_rvalid,
  output logic          ls_rvalid,
  output logic          if_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-5:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_cnt;
  logic            if_starved;
  ls_src_t         win_src;
  logic            win_we;
  logic [AW-5:0]   win_qw;
  logic [DW-1:0]   win_wdata;
  logic            cmd_rd;
  ls_src_t         cmd_src;
  logic            pre_valid;

  // Sub-quadword address bits are don't-care.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{dma_addr[3:0], ls_addr[3:0], if_addr[3:0]};

  assign if_starved = if_req && (starve_cnt == CntW'(STARVE_MAX));

  // Choose at most one winner per cycle; nothing is granted while in reset.
  always_comb begin
    win_src = SRC_NONE;
    if (!rst) begin
      if (if_starved)   win_src = SRC_IF;
      else if (dma_req) win_src = SRC_DMA;
      else if (ls_req)  win_src = SRC_LS;
      else if (if_req)  win_src = SRC_IF;
    end
  end

  assign dma_gnt = (win_src == SRC_DMA);
  assign ls_gnt  = (win_src == SRC_LS);
  assign if_gnt  = (win_src == SRC_IF);

  // Select the winner's request fields for capture.
  always_comb begin
    win_we    = 1'b0;
    win_qw    = if_addr[AW-1:4];
    win_wdata = '0;
    unique case (win_src)
      SRC_DMA: begin
        win_we    = dma_we;
        win_qw    = dma_addr[AW-1:4];
        win_wdata = dma_wdata;
      end
      SRC_LS: begin
        win_we    = ls_we;
        win_qw    = ls_addr[AW-1:4];
        win_wdata = ls_wdata;
      end
      SRC_IF:   win_qw = if_addr[AW-1:4];
      SRC_NONE: win_qw = if_addr[AW-1:4];
    endcase
  end

  // Count consecutive denied fetch cycles, saturating at the promotion threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt != CntW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Registered memory command; addr/wdata hold when idle, en/we drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_rd    <= 1'b0;
      cmd_src   <= SRC_NONE;
    end else if (win_src != SRC_NONE) begin
      mem_en    <= 1'b1;
      mem_we    <= win_we;
      mem_addr  <= win_qw;
      mem_wdata <= win_wdata;
      cmd_rd    <= !win_we;
      cmd_src   <= win_src;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      cmd_rd    <= 1'b0;
    end
  end

  // Tag pipe starts at the command stage so its last stage lines up with registered rdata.
  ls_rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (cmd_rd),
    .in_src    (cmd_src),
    .pre_valid (pre_valid),
    .dma_rvalid(dma_rvalid),
    .ls_rvalid (ls_rvalid),
    .if_rvalid (if_rvalid)
  );

  // Capture array read data in the cycle it is valid for a tracked read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (pre_valid) begin
      rdata <= mem_rdata;
    end
  end

endmodule
